// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: state encoding and width helpers for the FFT stage sequencer
package fft_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_EXT, CFILL, CALC, LOAD_FB, DONE} state_e;
  function automatic int nstage(int n);
    return $clog2(n);
  endfunction
  function automatic int addr_w(int n);
    return $clog2(n);
  endfunction
  function automatic int stage_w(int n);
    return $clog2(n / 4);
  endfunction
  function automatic int fill_w(int c);
    return $clog2(c + 1);
  endfunction
endpackage

// File: rtl/fft_stage_sequencer_word_mux.sv
// fft_word_mux: combinational select of one MSB-wide word from an N-word bus
module fft_word_mux #(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic [N*MSB-1:0]     data,
  input  logic [$clog2(N)-1:0] sel,
  output logic [MSB-1:0]       word
);
  assign word = data[sel*MSB +: MSB];
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: loads N samples, then drives fill/calc/write-back for every FFT stage
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N             = 16,
  parameter int MSB           = 16,
  parameter int C_FILL_CYCLES = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [MSB-1:0]             s_data,
  input  logic [N*MSB-1:0]           fb_data,
  input  logic                       calc_finish,
  output logic [MSB-1:0]             data_in,
  output logic [$clog2(N)-1:0]       addr_counter,
  output logic [$clog2(N/4)-1:0]     stage,
  output logic                       fill_regs,
  output logic                       start_calc,
  output logic                       busy,
  output logic                       out_valid
);
  localparam int NSTAGE  = nstage(N);
  localparam int ADDR_W  = addr_w(N);
  localparam int STAGE_W = stage_w(N);
  localparam int FILL_W  = fill_w(C_FILL_CYCLES);
  state_e state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d, addr_q, addr_d, sel;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [MSB-1:0]     data_q, data_d, fb_word;
  logic fill_q, fill_d, start_q, start_d, ready_q, ready_d, busy_q, busy_d, ovalid_q, ovalid_d;
  logic hs;
  assign hs = s_valid & ready_q;
  // fb word is fetched one cycle ahead so data_in and addr_counter land together
  assign sel = (state_q == CALC) ? '0 : addr_q + 1'b1;
  fft_word_mux #(.N(N), .MSB(MSB)) u_mux (.data(fb_data), .sel(sel), .word(fb_word));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    stage_d    = stage_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = LOAD_EXT;
        cnt_d   = ADDR_W'(1);
        addr_d  = '0;
        data_d  = s_data;
        stage_d = '0;
      end
      LOAD_EXT: if (hs) begin
        data_d  = s_data;
        addr_d  = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == ADDR_W'(N - 1)) ? CFILL : LOAD_EXT;
      end
      CFILL: begin
        fill_cnt_d = (fill_cnt_q == FILL_W'(C_FILL_CYCLES - 1)) ? '0 : fill_cnt_q + 1'b1;
        state_d    = (fill_cnt_q == FILL_W'(C_FILL_CYCLES - 1)) ? CALC : CFILL;
      end
      // start_q marks the pulse cycle, in which calc_finish is not yet meaningful
      CALC: if (!start_q && calc_finish) begin
        if (stage_q == STAGE_W'(NSTAGE - 1)) state_d = DONE;
        else begin
          state_d = LOAD_FB;
          stage_d = stage_q + 1'b1;
          addr_d  = '0;
          data_d  = fb_word;
        end
      end
      LOAD_FB: if (addr_q == ADDR_W'(N - 1)) state_d = CFILL;
      else begin
        addr_d = addr_q + 1'b1;
        data_d = fb_word;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fill_d   = (state_d == CFILL) && (state_q != CFILL);
    start_d  = (state_d == CALC) && (state_q != CALC);
    ovalid_d = (state_d == DONE);
    ready_d  = (state_d == IDLE) || (state_d == LOAD_EXT);
    busy_d   = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      stage_q    <= '0;
      fill_cnt_q <= '0;
      fill_q     <= 1'b0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      stage_q    <= stage_d;
      fill_cnt_q <= fill_cnt_d;
      fill_q     <= fill_d;
      start_q    <= start_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ovalid_q   <= ovalid_d;
    end
  end
  assign s_ready      = ready_q;
  assign data_in      = data_q;
  assign addr_counter = addr_q;
  assign stage        = stage_q;
  assign fill_regs    = fill_q;
  assign start_calc   = start_q;
  assign busy         = busy_q;
  assign out_valid    = ovalid_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: transform-level checks with a stub stage and random stimulus
module tb_fft_stage_sequencer;
  localparam int N = 16, MSB = 16, C = 12, NST = 4;
  typedef struct {
    int gm;
    int lat;
    bit lvl;
    int abort_st;
    int exp_start;
    int exp_ov;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, calc_finish = 1'b0;
  logic [MSB-1:0] s_data = '0;
  logic [N*MSB-1:0] fb_data = '0;
  logic s_ready, fill_regs, start_calc, busy, out_valid;
  logic [MSB-1:0] data_in;
  logic [3:0] addr_counter;
  logic [1:0] stage;
  int checks = 0, errors = 0, cyc = 0;
  int n_fill = 0, n_start = 0, n_ov = 0;
  bit cur_lvl = 0;
  logic [MSB-1:0] smp[N], fbw[N];
  vec_t tbl[6];

  fft_stage_sequencer #(.N(N), .MSB(MSB), .C_FILL_CYCLES(C)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fb_data(fb_data), .calc_finish(calc_finish), .data_in(data_in),
    .addr_counter(addr_counter), .stage(stage), .fill_regs(fill_regs),
    .start_calc(start_calc), .busy(busy), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (fill_regs) n_fill++;
    if (start_calc) n_start++;
    if (out_valid) n_ov++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    s_valid = 1'($urandom_range(0, 1));
    s_data  = MSB'($urandom);
    calc_finish = cur_lvl ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_data_in"}, data_in, 0);
    chk({nm, "_addr"}, addr_counter, 0);
    chk({nm, "_stage"}, stage, 0);
    chk({nm, "_fill"}, fill_regs, 0);
    chk({nm, "_start"}, start_calc, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
  endtask

  task automatic run(input vec_t v, output bit aborted);
    int lat, k, gaps, t0, guard;
    bit tog, vld, hs;
    logic [MSB-1:0] last;
    aborted = 0;
    lat = v.lvl ? 1 : (v.lat == 0 ? int'($urandom_range(1, 8)) : v.lat);
    cur_lvl = v.lvl;
    for (int i = 0; i < N; i++) smp[i] = (v.gm == 0) ? MSB'(i + 1) : MSB'($urandom);
    k = 0; gaps = 0; t0 = 0; guard = 0; tog = 1;
    while (k < N) begin
      vld = (v.gm == 0) ? 1'b1 : (v.gm == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      s_valid = vld;
      s_data  = vld ? smp[k] : MSB'($urandom);
      calc_finish = v.lvl ? 1'b1 : 1'($urandom_range(0, 1));
      hs = vld && s_ready;
      if (hs && k == 0) t0 = cyc;
      if (!hs && k > 0) gaps++;
      tick();
      if (hs) begin
        chk("load_addr", addr_counter, k);
        chk("load_data", data_in, smp[k]);
        k++;
      end else if (k > 0) begin
        chk("gap_addr", addr_counter, k - 1);
        chk("gap_data", data_in, smp[k-1]);
      end
      if (k > 0) chk("load_stage", stage, 0);
      chk("load_s_ready", s_ready, k < N);
      chk("load_fill", fill_regs, k == N);
      if (++guard > 300) begin
        chk("load_timeout", k, N);
        return;
      end
    end
    last = smp[N-1];
    for (int s = 0; s < NST; s++) begin
      for (int i = 1; i < C; i++) begin
        noise();
        tick();
        chk("fill_wait_start", start_calc, 0);
        chk("fill_wait_ready", s_ready, 0);
        chk("fill_wait_addr", addr_counter, N - 1);
        chk("fill_wait_data", data_in, last);
      end
      noise();
      tick();
      chk("start_pulse", start_calc, 1);
      chk("calc_stage", stage, s);
      chk("calc_s_ready", s_ready, 0);
      for (int i = 0; i < N; i++) begin
        fbw[i] = (v.gm == 0) ? MSB'(16'h100 + i) : MSB'($urandom);
        fb_data[i*MSB +: MSB] = fbw[i];
      end
      for (int i = 1; i <= lat + 1; i++) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = MSB'($urandom);
        calc_finish = v.lvl || (i == lat + 1) || (i == 1 && $urandom_range(0, 1) == 1);
        tick();
        if (i <= lat) begin
          chk("calc_hold_start", start_calc, 0);
          chk("calc_hold_ov", out_valid, 0);
          chk("calc_hold_stage", stage, s);
          chk("calc_hold_data", data_in, last);
          chk("calc_s_ready", s_ready, 0);
        end
      end
      if (s == NST - 1) begin
        chk("out_valid", out_valid, 1);
        chk("busy_done", busy, 1);
        if (v.gm != 1) chk("cycle_budget", cyc - t0 + 1, N + gaps + NST * (C + lat + 1) + (NST - 1) * N + 1);
        noise();
        tick();
        chk("out_valid_drop", out_valid, 0);
        chk("busy_drop", busy, 0);
        chk("idle_s_ready", s_ready, 1);
      end else begin
        chk("fb_stage", stage, s + 1);
        chk("fb_addr0", addr_counter, 0);
        chk("fb_data0", data_in, fbw[0]);
        for (int j = 1; j < N; j++) begin
          if (s + 1 == v.abort_st && j == 5) begin
            rst_n = 1'b0;
            #1;
            chk_zero("abort");
            aborted = 1;
            return;
          end
          noise();
          tick();
          chk("fb_addr", addr_counter, j);
          chk("fb_data", data_in, fbw[j]);
          chk("fb_stage_hold", stage, s + 1);
          chk("fb_s_ready", s_ready, 0);
        end
        noise();
        tick();
        chk("refill_pulse", fill_regs, 1);
        chk("refill_addr", addr_counter, N - 1);
        chk("refill_data", data_in, fbw[N-1]);
        last = fbw[N-1];
      end
    end
  endtask

  initial begin
    bit ab;
    int f0, s0, o0;
    tbl[0] = '{gm: 0, lat: 5, lvl: 0, abort_st: -1, exp_start: 4, exp_ov: 1};
    tbl[1] = '{gm: 1, lat: 3, lvl: 0, abort_st: -1, exp_start: 4, exp_ov: 1};
    tbl[2] = '{gm: 0, lat: 1, lvl: 1, abort_st: -1, exp_start: 4, exp_ov: 1};
    tbl[3] = '{gm: 0, lat: 5, lvl: 0, abort_st: 2, exp_start: 2, exp_ov: 0};
    tbl[4] = '{gm: 2, lat: 0, lvl: 0, abort_st: -1, exp_start: 4, exp_ov: 1};
    tbl[5] = '{gm: 2, lat: 0, lvl: 0, abort_st: -1, exp_start: 4, exp_ov: 1};
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", s_ready, 1);
    chk("post_reset_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b0;
      calc_finish = 1'b1;
      tick();
      chk("idle_spurious_busy", busy, 0);
      chk("idle_spurious_ready", s_ready, 1);
      chk("idle_spurious_start", start_calc, 0);
      chk("idle_spurious_fill", fill_regs, 0);
    end
    calc_finish = 1'b0;
    for (int r = 0; r < 6; r++) begin
      f0 = n_fill; s0 = n_start; o0 = n_ov;
      run(tbl[r], ab);
      s_valid = 1'b0;
      calc_finish = 1'b0;
      tick();
      tick();
      chk("fill_count", n_fill - f0, tbl[r].exp_start);
      chk("start_count", n_start - s0, tbl[r].exp_start);
      chk("out_valid_count", n_ov - o0, tbl[r].exp_ov);
      if (ab) begin
        chk("abort_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_recover_ready", s_ready, 1);
        chk("abort_recover_busy", busy, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
